// File: rtl/fifo_credit_arbiter.sv
// Round-robin, credit-gated write scheduler for the variable-burst FIFO.
// Optional FIFO_CREDIT_ARB_ERR_EN adds sticky overflow/protocol error outputs.
module fifo_credit_arbiter #(
    parameter int NREQ     = 4,
    parameter int CAPACITY = 256,
    parameter int CW       = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_i,
    input  logic [4*NREQ-1:0]     req_size_i,
    input  logic [256*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [255:0]          fifo_data_o,
    output logic [3:0]            fifo_size_o,
    output logic                  fifo_we_o,
    input  logic                  credit_ret_i,
    output logic [CW-1:0]         credits_o,
    output logic                  wait_o
`ifdef FIFO_CREDIT_ARB_ERR_EN
    ,
    output logic                  err_o,
    output logic [1:0]            err_code_o
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] IDLE        = 1'b0;
    localparam logic [0:0] WAIT_CREDIT = 1'b1;

    logic [0:0]      state_reg, state_next;
    logic [PW-1:0]   ptr_reg;
    logic [PW-1:0]   lock_reg, lock_next;
    logic [CW-1:0]   credits_reg, credits_next;
    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic            we_reg;
    logic [255:0]    data_reg;
    logic [3:0]      size_reg;

    logic [CW-1:0]   need [NREQ];
    logic [255:0]    data_arr [NREQ];
    logic [3:0]      size_arr [NREQ];

    logic [NREQ-1:0] eligible;
    logic            cand_found;
    logic [PW-1:0]   cand_idx;
    logic            issue;
    logic [PW-1:0]   issue_idx;
    logic [CW:0]     credit_sum;

    // Size code 0 encodes a full 16-word burst.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign size_arr[gi] = req_size_i[4*gi +: 4];
            assign data_arr[gi] = req_data_i[256*gi +: 256];
            assign need[gi]     = (size_arr[gi] == 4'd0) ? CW'(16) : CW'(size_arr[gi]);
        end
    endgenerate

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    assign eligible = req_i & ~gnt_reg;

    // Scan from the farthest offset down so the nearest eligible index at/after ptr wins.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (eligible[wrap_idx(ptr_reg, j)]) begin
                cand_found = 1'b1;
                cand_idx   = wrap_idx(ptr_reg, j);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        lock_next  = lock_reg;
        issue      = 1'b0;
        issue_idx  = cand_idx;
        case (state_reg)
            IDLE: begin
                if (cand_found) begin
                    if (credits_reg >= need[cand_idx]) begin
                        issue = 1'b1;
                    end else begin
                        lock_next  = cand_idx;
                        state_next = WAIT_CREDIT;
                    end
                end
            end
            WAIT_CREDIT: begin
                issue_idx = lock_reg;
                if (!req_i[lock_reg]) begin
                    state_next = IDLE;
                end else if (credits_reg >= need[lock_reg]) begin
                    issue      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign gnt_next   = issue ? ({{(NREQ-1){1'b0}}, 1'b1} << issue_idx) : '0;
    assign credit_sum = {1'b0, credits_reg}
                      - (issue ? {1'b0, need[issue_idx]} : '0)
                      + {{CW{1'b0}}, credit_ret_i};
    assign credits_next = (credit_sum > (CW+1)'(CAPACITY)) ? CW'(CAPACITY) : credit_sum[CW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            lock_reg    <= '0;
            credits_reg <= CW'(CAPACITY);
            gnt_reg     <= '0;
            we_reg      <= 1'b0;
            data_reg    <= '0;
            size_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            lock_reg    <= lock_next;
            credits_reg <= credits_next;
            gnt_reg     <= gnt_next;
            we_reg      <= issue;
            if (issue) begin
                data_reg <= data_arr[issue_idx];
                size_reg <= size_arr[issue_idx];
                ptr_reg  <= wrap_idx(issue_idx, 1);
            end
        end
    end

    assign gnt_o       = gnt_reg;
    assign fifo_we_o   = we_reg;
    assign fifo_data_o = data_reg;
    assign fifo_size_o = size_reg;
    assign credits_o   = credits_reg;
    assign wait_o      = (state_reg == WAIT_CREDIT);

`ifdef FIFO_CREDIT_ARB_ERR_EN
    logic [NREQ-1:0] pending_reg;
    logic [1:0]      err_code_reg;
    logic            overflow_evt;
    logic            drop_evt;

    // A request is only "pending" outside its own grant cycle, so dropping it after gnt is legal.
    assign overflow_evt = credit_ret_i & ~issue & (credits_reg == CW'(CAPACITY));
    assign drop_evt     = |(pending_reg & ~req_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg  <= '0;
            err_code_reg <= '0;
        end else begin
            pending_reg  <= req_i & ~gnt_next & ~gnt_reg;
            err_code_reg <= err_code_reg | {drop_evt, overflow_evt};
        end
    end

    assign err_code_o = err_code_reg;
    assign err_o      = |err_code_reg;
`endif

endmodule

// File: tb/tb_fifo_credit_arbiter.sv
// Directed self-checking bench for fifo_credit_arbiter (NREQ=4, CAPACITY=256).
module tb_fifo_credit_arbiter;

    localparam int NREQ = 4;
    localparam int CW   = 9;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NREQ-1:0]     req_i = '0;
    logic [4*NREQ-1:0]   req_size_i = '0;
    logic [256*NREQ-1:0] req_data_i = '0;
    logic [NREQ-1:0]     gnt_o;
    logic [255:0]        fifo_data_o;
    logic [3:0]          fifo_size_o;
    logic                fifo_we_o;
    logic                credit_ret_i = 1'b0;
    logic [CW-1:0]       credits_o;
    logic                wait_o;
`ifdef FIFO_CREDIT_ARB_ERR_EN
    logic                err_o;
    logic [1:0]          err_code_o;
`endif

    int checks = 0;
    int errors = 0;

    fifo_credit_arbiter #(.NREQ(NREQ), .CAPACITY(256), .CW(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_i        (req_i),
        .req_size_i   (req_size_i),
        .req_data_i   (req_data_i),
        .gnt_o        (gnt_o),
        .fifo_data_o  (fifo_data_o),
        .fifo_size_o  (fifo_size_o),
        .fifo_we_o    (fifo_we_o),
        .credit_ret_i (credit_ret_i),
        .credits_o    (credits_o),
        .wait_o       (wait_o)
`ifdef FIFO_CREDIT_ARB_ERR_EN
        ,
        .err_o        (err_o),
        .err_code_o   (err_code_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n      = 1'b0;
        req_i        = '0;
        req_size_i   = '0;
        credit_ret_i = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // One burst from requester idx: request, expect grant on the next edge, then release.
    task automatic issue_one(input int idx, input logic [3:0] sz);
        logic [NREQ-1:0] exp_g;
        exp_g = '0;
        exp_g[idx] = 1'b1;
        req_i[idx] = 1'b1;
        req_size_i[4*idx +: 4] = sz;
        tick();
        checks++;
        if (gnt_o !== exp_g) begin
            errors++;
            $display("FAIL burst_gnt: gnt_o=%b expected %b", gnt_o, exp_g);
        end
        req_i[idx] = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        checks += 6;
        if (gnt_o !== 4'b0000)       begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt_o); end
        if (fifo_we_o !== 1'b0)      begin errors++; $display("FAIL reset_we: got %b expected 0", fifo_we_o); end
        if (fifo_data_o !== 256'd0)  begin errors++; $display("FAIL reset_data: got %h expected 0", fifo_data_o); end
        if (fifo_size_o !== 4'd0)    begin errors++; $display("FAIL reset_size: got %0d expected 0", fifo_size_o); end
        if (credits_o !== 9'd256)    begin errors++; $display("FAIL reset_credits: got %0d expected 256", credits_o); end
        if (wait_o !== 1'b0)         begin errors++; $display("FAIL reset_wait: got %b expected 0", wait_o); end
        $display("test_reset: outputs checked after reset");
    endtask

    task automatic test_single;
        logic [255:0] exp_d;
        exp_d = {16{16'hA000}};
        do_reset();
        req_i = 4'b0001;
        req_size_i = 16'h0004;
        tick();
        checks += 5;
        if (fifo_we_o !== 1'b1)     begin errors++; $display("FAIL single_we: got %b expected 1", fifo_we_o); end
        if (fifo_size_o !== 4'd4)   begin errors++; $display("FAIL single_size: got %0d expected 4", fifo_size_o); end
        if (gnt_o !== 4'b0001)      begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt_o); end
        if (fifo_data_o !== exp_d)  begin errors++; $display("FAIL single_data: got %h expected %h", fifo_data_o, exp_d); end
        if (credits_o !== 9'd252)   begin errors++; $display("FAIL single_credits: got %0d expected 252", credits_o); end
        req_i = 4'b0000;
        tick();
        checks += 3;
        if (fifo_we_o !== 1'b0)     begin errors++; $display("FAIL single_we_pulse: got %b expected 0", fifo_we_o); end
        if (gnt_o !== 4'b0000)      begin errors++; $display("FAIL single_gnt_pulse: got %b expected 0000", gnt_o); end
        if (credits_o !== 9'd252)   begin errors++; $display("FAIL single_credits_hold: got %0d expected 252", credits_o); end
        $display("test_single: size-4 burst from requester 0, credits=%0d", credits_o);
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0] exp_g;
        do_reset();
        req_size_i = 16'h1111;
        req_i = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            exp_g = 4'b0001 << (c % 4);
            checks++;
            if (gnt_o !== exp_g) begin
                errors++;
                $display("FAIL rr_gnt[%0d]: got %b expected %b", c, gnt_o, exp_g);
            end
            $display("test_round_robin: cycle %0d gnt=%b", c, gnt_o);
        end
        req_i = 4'b0000;
        tick();
        checks++;
        if (credits_o !== 9'd248) begin errors++; $display("FAIL rr_credits: got %0d expected 248", credits_o); end
    endtask

    task automatic test_wait_credit;
        do_reset();
        for (int b = 0; b < 15; b++) issue_one(0, 4'd0);
        issue_one(0, 4'd6);
        checks++;
        if (credits_o !== 9'd10) begin errors++; $display("FAIL drain_credits: got %0d expected 10", credits_o); end
        req_size_i = 16'h1000;
        req_i = 4'b1100;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks += 2;
            if (wait_o !== 1'b1)   begin errors++; $display("FAIL wait_enter[%0d]: got %b expected 1", c, wait_o); end
            if (gnt_o !== 4'b0000) begin errors++; $display("FAIL wait_nogrant[%0d]: got %b expected 0000", c, gnt_o); end
        end
        for (int r = 0; r < 6; r++) begin
            credit_ret_i = 1'b1;
            tick();
        end
        credit_ret_i = 1'b0;
        checks += 3;
        if (credits_o !== 9'd16) begin errors++; $display("FAIL wait_refill: got %0d expected 16", credits_o); end
        if (wait_o !== 1'b1)     begin errors++; $display("FAIL wait_hold: got %b expected 1", wait_o); end
        if (gnt_o !== 4'b0000)   begin errors++; $display("FAIL wait_hold_gnt: got %b expected 0000", gnt_o); end
        tick();
        checks += 4;
        if (gnt_o !== 4'b0100)   begin errors++; $display("FAIL wait_issue_gnt: got %b expected 0100", gnt_o); end
        if (credits_o !== 9'd0)  begin errors++; $display("FAIL wait_issue_credits: got %0d expected 0", credits_o); end
        if (wait_o !== 1'b0)     begin errors++; $display("FAIL wait_exit: got %b expected 0", wait_o); end
        if (fifo_size_o !== 4'd0) begin errors++; $display("FAIL wait_issue_size: got %0d expected 0", fifo_size_o); end
        req_i = 4'b0000;
        tick();
        $display("test_wait_credit: 16-word burst issued at credits 16, credits=%0d", credits_o);
    endtask

    task automatic test_issue_and_return;
        do_reset();
        for (int b = 0; b < 9; b++) issue_one(0, 4'd0);
        issue_one(0, 4'd12);
        checks++;
        if (credits_o !== 9'd100) begin errors++; $display("FAIL drain100: got %0d expected 100", credits_o); end
        req_i = 4'b0001;
        req_size_i = 16'h0008;
        credit_ret_i = 1'b1;
        tick();
        credit_ret_i = 1'b0;
        req_i = 4'b0000;
        checks += 3;
        if (credits_o !== 9'd93)  begin errors++; $display("FAIL issue_ret_credits: got %0d expected 93", credits_o); end
        if (fifo_we_o !== 1'b1)   begin errors++; $display("FAIL issue_ret_we: got %b expected 1", fifo_we_o); end
        if (fifo_size_o !== 4'd8) begin errors++; $display("FAIL issue_ret_size: got %0d expected 8", fifo_size_o); end
        tick();
        $display("test_issue_and_return: credits=%0d", credits_o);
    endtask

    task automatic test_saturate;
        do_reset();
        credit_ret_i = 1'b1;
        tick();
        credit_ret_i = 1'b0;
        checks++;
        if (credits_o !== 9'd256) begin errors++; $display("FAIL saturate_credits: got %0d expected 256", credits_o); end
`ifdef FIFO_CREDIT_ARB_ERR_EN
        checks += 2;
        if (err_o !== 1'b1)         begin errors++; $display("FAIL err_flag: got %b expected 1", err_o); end
        if (err_code_o !== 2'b01)   begin errors++; $display("FAIL err_code: got %b expected 01", err_code_o); end
`endif
        tick();
        checks++;
        if (credits_o !== 9'd256) begin errors++; $display("FAIL saturate_hold: got %0d expected 256", credits_o); end
        $display("test_saturate: credits=%0d", credits_o);
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        req_i = 4'b0001;
        req_size_i = 16'h0004;
        tick();
        checks++;
        if (fifo_we_o !== 1'b1) begin errors++; $display("FAIL mid_we_before: got %b expected 1", fifo_we_o); end
        #2;
        reset_n = 1'b0;
        #1;
        checks += 6;
        if (fifo_we_o !== 1'b0)     begin errors++; $display("FAIL mid_we: got %b expected 0", fifo_we_o); end
        if (gnt_o !== 4'b0000)      begin errors++; $display("FAIL mid_gnt: got %b expected 0000", gnt_o); end
        if (credits_o !== 9'd256)   begin errors++; $display("FAIL mid_credits: got %0d expected 256", credits_o); end
        if (fifo_size_o !== 4'd0)   begin errors++; $display("FAIL mid_size: got %0d expected 0", fifo_size_o); end
        if (fifo_data_o !== 256'd0) begin errors++; $display("FAIL mid_data: got %h expected 0", fifo_data_o); end
        if (wait_o !== 1'b0)        begin errors++; $display("FAIL mid_wait: got %b expected 0", wait_o); end
        req_i = 4'b1111;
        req_size_i = 16'h1111;
        #2;
        reset_n = 1'b1;
        tick();
        checks += 2;
        if (gnt_o !== 4'b0001)    begin errors++; $display("FAIL mid_restart_gnt: got %b expected 0001", gnt_o); end
        if (credits_o !== 9'd255) begin errors++; $display("FAIL mid_restart_credits: got %0d expected 255", credits_o); end
        req_i = 4'b0000;
        tick();
        $display("test_reset_mid_burst: restart grant=%b", gnt_o);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            req_data_i[256*i +: 256] = {16{16'hA000 | 16'(i)}};
        end
        test_reset();
        test_single();
        test_round_robin();
        test_wait_credit();
        test_issue_and_return();
        test_saturate();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_credit_arbiter.md
Name: fifo_credit_arbiter

Overview:
- Write-side scheduler for the 256-word variable-burst FIFO.
- Shares the FIFO write port (data 256 bits, size 4 bits, write enable) among NREQ requesters using round-robin arbitration.
- Issues a burst only when the local word-credit counter covers the whole burst, so the FIFO never overflows.
- Credits are returned one word at a time from the FIFO read side (read strobe qualified by not-empty).

Parameters:
- NREQ, 4, number of requesters (2..8).
- CAPACITY, 256, FIFO depth in 16-bit words; also the credit reset value.
- CW, 9, credit counter width; must hold CAPACITY.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_i  in  NREQ  per-requester burst request, level.
- req_size_i  in  4*NREQ  words in burst for requester i, slice [4i+:4]; 0 means 16.
- req_data_i  in  256*NREQ  burst data for requester i, slice [256i+:256], word 0 in bits [15:0].
- gnt_o  out  NREQ  one-hot, one-cycle pulse: burst of requester i was accepted.
- fifo_data_o  out  256  to FIFO data_i.
- fifo_size_o  out  4  to FIFO size_i.
- fifo_we_o  out  1  to FIFO data_we.
- credit_ret_i  in  1  one word consumed (FIFO data_rd & ~empty).
- credits_o  out  CW  current free-word credits.
- wait_o  out  1  high while in WAIT_CREDIT.

Behaviour:
- Reset values: gnt_o=0, fifo_we_o=0, fifo_data_o=0, fifo_size_o=0, credits_o=CAPACITY, wait_o=0, rr pointer=0, state=IDLE.
- All outputs are registered.
- Size decode: n = (size==0) ? 16 : size, range 1..16, zero-extended to CW.
- Eligible set: req_i[i] & ~gnt_o[i]. A requester granted in cycle T is not eligible in cycle T, so the same requester is at most every other cycle.
- Round robin: candidate = first eligible index at or after ptr, wrapping. After a grant to index k, ptr=(k+1) mod NREQ.
- FSM IDLE:
  - No eligible requester -> stay.
  - Candidate k with credits>=n_k -> issue at next edge; stay IDLE.
  - Credits<n_k -> lock k, go WAIT_CREDIT. No skipping to smaller bursts, so large bursts do not starve.
- FSM WAIT_CREDIT:
  - wait_o=1. Only locked k is considered.
  - credits>=n_k -> issue, go IDLE.
  - req_i[k] dropped -> go IDLE with no grant.
- Issue at edge E: fifo_data_o<=req_data_i[k], fifo_size_o<=req_size_i[k], fifo_we_o<=1, gnt_o[k]<=1. All are high for exactly the cycle after E.
- Requester protocol: hold req, size and data stable until gnt seen; then deassert or present the next burst.
- Credit update each cycle: credits <= credits - (issue ? n_k : 0) + credit_ret_i.
- Eligibility uses registered credits only. A same-cycle return counts from the next cycle.
- Boundaries:
  - credits==16 with a 16-word request: issue, credits->0, or 1 if a return arrives the same cycle.
  - credits==0: no issue; returns still accepted.
  - credit_ret_i at credits==CAPACITY with no issue: ignored, counter saturates.
  - Issue and return in the same cycle are both applied.
  - ptr wraps from NREQ-1 to 0.
- Reset asserted mid-burst: immediate asynchronous clear. An in-flight fifo_we_o is dropped; the FIFO is reset alongside.

Optional Feature:
- Macro: FIFO_CREDIT_ARB_ERR_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0) and err_code_o (2 bits, reset 0).
  - err_code_o bit0 is a sticky flag: credit return at CAPACITY (overflow).
  - err_code_o bit1 is a sticky flag: any req_i[i] dropped before its grant (protocol violation).
  - err_o = |err_code_o. Cleared only by reset.
- Undefined: no ports and no logic added; overflow is silently saturated.

Test Plan:
- Reset, then req_i=0001 with size 4 -> at edge 2: fifo_we_o=1, fifo_size_o=4, gnt_o=0001; credits_o 256->252.
- req_i=1111 all held with size 1, credits 256 -> grant order 0,1,2,3,0,1,… One gnt per cycle, no requester granted two cycles in a row.
- Drain credits to 10, requester 2 requests size 0 (16 words) -> wait_o=1, no grants, including to a requester 3 size-1 request. Pulse credit_ret_i 6 times -> credits 16, then issue to requester 2; credits 0, wait_o=0.
- Issue size 8 and credit_ret_i=1 in the same cycle from credits 100 -> credits 93.
- With credits 256, pulse credit_ret_i -> credits stay 256. With FIFO_CREDIT_ARB_ERR_EN: err_o=1, err_code_o=01.
- Deassert reset_n between the issue edge and the next edge -> fifo_we_o, gnt_o and all other outputs clear asynchronously; credits_o=256; next request is granted starting from requester 0.
